// File: rtl/obj_dma_pkg.sv
// Shared definitions for the object-attribute DMA controller.
//   - FSM state encodings
//   - default AW/DW/ENTRIES
//   - DMA window line numbers and ticks per line of the video timing generator
package obj_dma_pkg;

  localparam int unsigned DefAw      = 10;
  localparam int unsigned DefDw      = 16;
  localparam int unsigned DefEntries = 1024;

  // Vertical DMA window supplied by the timing generator (active-low on these lines).
  localparam int unsigned DmaLineStart = 479;
  localparam int unsigned DmaLineEnd   = 494;
  localparam int unsigned TicksPerLine = 384;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StReq   = 3'd1;
  localparam logic [2:0] StCopy  = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

endpackage

// File: rtl/obj_dma_tick_edge.sv
// Tick-qualified sampler and falling-edge detector for the active-low DMA window.
// Ports:
//   clk    master clock
//   rst_n  asynchronous active-low reset
//   tick   pixel-clock enable (active high here)
//   sig_n  active-low DMA window input
//   fall   high on a tick where sig_n is low and the previous tick's sample was high
module obj_dma_tick_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sig_n,
  output logic fall
);

  logic prev_q;
  logic armed_q;

  // armed_q blocks the first tick after reset: a window that is already low when
  // reset is released must not look like a fresh falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
    end else if (tick) begin
      prev_q  <= sig_n;
      armed_q <= 1'b1;
    end
  end

  assign fall = tick & armed_q & prev_q & ~sig_n;

endmodule

// File: rtl/obj_dma_ctrl.sv
// Object-attribute DMA controller. Once per DMA window it requests the CPU bus, copies
// ENTRIES words from object RAM into the hidden bank of a double-buffered sprite shadow
// RAM, then flips the bank the sprite engine reads. Everything advances on pixel ticks.
// Ports:
//   i_EMU_MCLK, i_MRST_n     clock, asynchronous active-low reset
//   i_EMU_CLK6MPCEN_n        pixel enable (tick when low)
//   i_DMA_n, i_BG_n, o_BR_n  DMA window, bus grant, bus request (all active low)
//   o_SRC_ADDR, o_SRC_RD_n, i_SRC_DATA   object RAM read port
//   o_DST_ADDR, o_DST_DATA, o_DST_WR_n   shadow RAM write port, addr = {bank, word}
//   o_BANK, o_BUSY, o_ERR    displayed bank, copy in progress, last copy failed
module obj_dma_ctrl
  import obj_dma_pkg::*;
#(
  parameter int unsigned AW      = DefAw,
  parameter int unsigned DW      = DefDw,
  parameter int unsigned ENTRIES = DefEntries
) (
  input  logic          i_EMU_MCLK,
  input  logic          i_MRST_n,
  input  logic          i_EMU_CLK6MPCEN_n,
  input  logic          i_DMA_n,
  input  logic          i_BG_n,
  output logic          o_BR_n,
  output logic [AW-1:0] o_SRC_ADDR,
  output logic          o_SRC_RD_n,
  input  logic [DW-1:0] i_SRC_DATA,
  output logic [AW:0]   o_DST_ADDR,
  output logic [DW-1:0] o_DST_DATA,
  output logic          o_DST_WR_n,
  output logic          o_BANK,
  output logic          o_BUSY,
  output logic          o_ERR
);

  localparam logic [AW-1:0] LastWord   = AW'(ENTRIES - 1);
  localparam logic [AW-1:0] PenultWord = AW'((ENTRIES >= 2) ? ENTRIES - 2 : 0);
  localparam logic          SingleWord = (ENTRIES == 1);

  logic          tick;
  logic          dma_fall;

  logic [2:0]    state_q, state_d;
  logic          br_n_q, br_n_d;
  logic          rd_n_q, rd_n_d;
  logic          wr_n_q, wr_n_d;
  logic [AW-1:0] src_addr_q, src_addr_d;
  logic [AW:0]   dst_addr_q, dst_addr_d;
  logic [DW-1:0] dst_data_q, dst_data_d;
  logic          bank_q, bank_d;
  logic          err_q, err_d;

  assign tick = ~i_EMU_CLK6MPCEN_n;

  obj_dma_tick_edge u_dma_edge (
    .clk   (i_EMU_MCLK),
    .rst_n (i_MRST_n),
    .tick  (tick),
    .sig_n (i_DMA_n),
    .fall  (dma_fall)
  );

  always_comb begin
    state_d    = state_q;
    br_n_d     = br_n_q;
    rd_n_d     = rd_n_q;
    wr_n_d     = wr_n_q;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;
    bank_d     = bank_q;
    err_d      = err_q;

    case (state_q)
      StIdle: begin
        if (dma_fall) begin
          state_d = StReq;
          br_n_d  = 1'b0;
        end
      end

      StReq: begin
        if (i_DMA_n) begin
          state_d = StIdle;
          br_n_d  = 1'b1;
          err_d   = 1'b1;
        end else if (!i_BG_n) begin
          // Grant tick issues the first read.
          state_d    = StCopy;
          src_addr_d = '0;
          rd_n_d     = 1'b0;
        end
      end

      StCopy, StDrain: begin
        if (i_DMA_n || i_BG_n) begin
          // Abort: the bank is not flipped, so any partial data stays hidden.
          state_d = StIdle;
          br_n_d  = 1'b1;
          rd_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          err_d   = 1'b1;
        end else if (state_q == StCopy) begin
          // A read is always outstanding in COPY, so every tick writes the previous word.
          wr_n_d     = 1'b0;
          dst_addr_d = {~bank_q, src_addr_q};
          dst_data_d = i_SRC_DATA;
          if (src_addr_q != LastWord) begin
            src_addr_d = src_addr_q + AW'(1);
          end
          if (SingleWord || src_addr_q == PenultWord) begin
            rd_n_d  = 1'b1;
            state_d = StDrain;
          end
        end else if (!wr_n_q && dst_addr_q[AW-1:0] == LastWord) begin
          // Last word has been written: release the bus and show the new bank.
          state_d = StDone;
          wr_n_d  = 1'b1;
          br_n_d  = 1'b1;
          bank_d  = ~bank_q;
          err_d   = 1'b0;
        end else begin
          wr_n_d     = 1'b0;
          dst_addr_d = {~bank_q, src_addr_q};
          dst_data_d = i_SRC_DATA;
        end
      end

      StDone: begin
        if (i_DMA_n) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      state_q    <= StIdle;
      br_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
      bank_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (tick) begin
      state_q    <= state_d;
      br_n_q     <= br_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
      bank_q     <= bank_d;
      err_q      <= err_d;
    end
  end

  assign o_BR_n     = br_n_q;
  assign o_SRC_ADDR = src_addr_q;
  assign o_SRC_RD_n = rd_n_q;
  assign o_DST_ADDR = dst_addr_q;
  assign o_DST_DATA = dst_data_q;
  assign o_DST_WR_n = wr_n_q;
  assign o_BANK     = bank_q;
  assign o_ERR      = err_q;
  assign o_BUSY     = (state_q == StReq) || (state_q == StCopy) || (state_q == StDrain);

endmodule

// File: tb/tb_obj_dma_ctrl.sv
// Bench for obj_dma_ctrl: a default-size instance (1024 words) and a 4-word instance.
module tb_obj_dma_ctrl;

  localparam int unsigned E  = 1024;
  localparam int unsigned E4 = 4;

  typedef struct {
    logic [10:0] addr;
    logic [15:0] data;
    int          tick;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en_n  = 1'b1;

  logic        dma_n = 1'b1, bg_n = 1'b1;
  logic        br_n, src_rd_n, dst_wr_n, bank, busy, err;
  logic [9:0]  src_addr;
  logic [15:0] src_data, dst_data;
  logic [10:0] dst_addr;

  logic        dma_n4 = 1'b1, bg_n4 = 1'b1;
  logic        br_n4, src_rd_n4, dst_wr_n4, bank4, busy4, err4;
  logic [9:0]  src_addr4;
  logic [15:0] src_data4, dst_data4;
  logic [10:0] dst_addr4;

  logic [15:0] mem  [E];
  logic [15:0] mem4 [E4];

  // Object RAM: asynchronous read, so data for an address is ready by the next tick.
  assign src_data  = mem[src_addr];
  assign src_data4 = mem4[src_addr4[1:0]];

  obj_dma_ctrl u_dut (
    .i_EMU_MCLK        (clk),
    .i_MRST_n          (rst_n),
    .i_EMU_CLK6MPCEN_n (en_n),
    .i_DMA_n           (dma_n),
    .i_BG_n            (bg_n),
    .o_BR_n            (br_n),
    .o_SRC_ADDR        (src_addr),
    .o_SRC_RD_n        (src_rd_n),
    .i_SRC_DATA        (src_data),
    .o_DST_ADDR        (dst_addr),
    .o_DST_DATA        (dst_data),
    .o_DST_WR_n        (dst_wr_n),
    .o_BANK            (bank),
    .o_BUSY            (busy),
    .o_ERR             (err)
  );

  obj_dma_ctrl #(.ENTRIES(E4)) u_dut4 (
    .i_EMU_MCLK        (clk),
    .i_MRST_n          (rst_n),
    .i_EMU_CLK6MPCEN_n (en_n),
    .i_DMA_n           (dma_n4),
    .i_BG_n            (bg_n4),
    .o_BR_n            (br_n4),
    .o_SRC_ADDR        (src_addr4),
    .o_SRC_RD_n        (src_rd_n4),
    .i_SRC_DATA        (src_data4),
    .o_DST_ADDR        (dst_addr4),
    .o_DST_DATA        (dst_data4),
    .o_DST_WR_n        (dst_wr_n4),
    .o_BANK            (bank4),
    .o_BUSY            (busy4),
    .o_ERR             (err4)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  int   tick_cnt = 0;
  logic edge_tick = 1'b0;
  int   en_mode = 0;
  int   en_period = 8;
  int   phase = 0;
  int   gap_cnt = 0;
  logic m_bank = 1'b0;
  wr_t  wq[$];
  wr_t  wq4[$];

  always @(posedge clk) edge_tick <= ~en_n;

  // Tick counter, shadow-RAM write capture (one write per tick with the strobe low),
  // and the pixel-enable generator.
  always @(negedge clk) begin
    if (edge_tick) begin
      tick_cnt = tick_cnt + 1;
      if (!dst_wr_n)  wq.push_back('{addr: dst_addr, data: dst_data, tick: tick_cnt});
      if (!dst_wr_n4) wq4.push_back('{addr: dst_addr4, data: dst_data4, tick: tick_cnt});
    end
    if (en_mode == 1) begin
      if (gap_cnt == 0) begin
        en_n    = 1'b0;
        gap_cnt = $urandom_range(20, 1);
      end else begin
        en_n    = 1'b1;
        gap_cnt = gap_cnt - 1;
      end
    end else begin
      en_n  = (phase == 0) ? 1'b0 : 1'b1;
      phase = (phase + 1) % en_period;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_tick_cnt(input int t);
    int guard = 0;
    while (tick_cnt < t && guard < 200000) begin
      step();
      guard++;
    end
    if (tick_cnt < t) begin
      n_vec++;
      n_bad++;
      $display("FAIL tick_timeout: reached tick %0d want %0d", tick_cnt, t);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < int'(E); i++) mem[i] = 16'($urandom);
    for (int i = 0; i < int'(E4); i++) mem4[i] = 16'($urandom);
  endtask

  // Lower DMA_n, grant after bg_delay ticks of request; g is the grant tick.
  task automatic start_grant(input int bg_delay, output int g);
    int k;
    fill_mem();
    wq.delete();
    bg_n  = 1'b1;
    dma_n = 1'b0;
    k = tick_cnt;
    wait_tick_cnt(k + 1 + bg_delay);
    bg_n = 1'b0;
    g = tick_cnt + 1;
  endtask

  // Compare captured partial/full writes against the expected word sequence.
  task automatic check_words(input string name, input int n, input logic wbank, input int g);
    logic [10:0] ea;
    for (int i = 0; i < n && i < wq.size(); i++) begin
      ea = {wbank, 10'(i)};
      n_vec++;
      if ({wq[i].addr, wq[i].data} !== {ea, mem[i]}) begin
        n_bad++;
        $display("FAIL %s word[%0d]: got %h/%h want %h/%h", name, i, wq[i].addr, wq[i].data,
                 ea, mem[i]);
      end
      n_vec++;
      if (wq[i].tick != g + 1 + i) begin
        n_bad++;
        $display("FAIL %s wr_tick[%0d]: got %0d want %0d", name, i, wq[i].tick, g + 1 + i);
      end
    end
  endtask

  task automatic copy_window(input string name, input int bg_delay);
    int   k, g;
    logic old_bank;
    fill_mem();
    wq.delete();
    old_bank = m_bank;
    bg_n  = 1'b1;
    dma_n = 1'b0;
    k = tick_cnt;
    wait_tick_cnt(k + 1);
    n_vec++;
    if (br_n !== 1'b0) begin
      n_bad++;
      $display("FAIL %s br_latency: br_n=%b want 0", name, br_n);
    end
    wait_tick_cnt(k + 1 + bg_delay);
    bg_n = 1'b0;
    g = tick_cnt + 1;
    wait_tick_cnt(g);
    n_vec++;
    if ({src_rd_n, src_addr} !== 11'd0) begin
      n_bad++;
      $display("FAIL %s first_read: rd_n/addr=%b/%h want 0/000", name, src_rd_n, src_addr);
    end
    wait_tick_cnt(g + E);
    n_vec++;
    if ({br_n, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL %s hold_bus: br_n/busy=%b%b want 01", name, br_n, busy);
    end
    wait_tick_cnt(g + E + 1);
    m_bank = ~m_bank;
    n_vec++;
    if ({br_n, dst_wr_n, bank, err, busy} !== {2'b11, m_bank, 2'b00}) begin
      n_bad++;
      $display("FAIL %s release: br/wr/bank/err/busy=%b%b%b%b%b want 11%b00", name, br_n,
               dst_wr_n, bank, err, busy, m_bank);
    end
    n_vec++;
    if (wq.size() != E) begin
      n_bad++;
      $display("FAIL %s write_count: got %0d want %0d", name, wq.size(), E);
    end
    check_words(name, E, ~old_bank, g);
    bg_n  = 1'b1;
    dma_n = 1'b1;
    k = tick_cnt;
    wait_tick_cnt(k + 2);
    n_vec++;
    if ({busy, br_n, bank} !== {2'b01, m_bank}) begin
      n_bad++;
      $display("FAIL %s window_end: busy/br/bank=%b%b%b want 01%b", name, busy, br_n, bank,
               m_bank);
    end
  endtask

  task automatic test_reset();
    dma_n = 1'b0;
    repeat (6) step();
    n_vec++;
    if ({br_n, src_rd_n, dst_wr_n, bank, busy, err, src_addr, dst_addr, dst_data} !== {3'b111,
        3'b000, 37'd0}) begin
      n_bad++;
      $display("FAIL reset_values: br/rd/wr/bank/busy/err=%b%b%b%b%b%b addr=%h/%h data=%h",
               br_n, src_rd_n, dst_wr_n, bank, busy, err, src_addr, dst_addr, dst_data);
    end
    n_vec++;
    if ({br_n4, src_rd_n4, dst_wr_n4, bank4, busy4, err4} !== 6'b111000) begin
      n_bad++;
      $display("FAIL reset_values4: got %b want 111000",
               {br_n4, src_rd_n4, dst_wr_n4, bank4, busy4, err4});
    end
    rst_n = 1'b1;
    wait_tick_cnt(tick_cnt + 20);
    n_vec++;
    if ({br_n, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL low_at_reset_exit: br_n/busy=%b%b want 10", br_n, busy);
    end
    dma_n = 1'b1;
    wait_tick_cnt(tick_cnt + 2);
  endtask

  task automatic test_normal_copy();
    en_mode = 0; en_period = 8; phase = 0;
    copy_window("normal", 3);
  endtask

  task automatic test_no_grant();
    int k;
    en_mode = 0; en_period = 1; phase = 0;
    wq.delete();
    bg_n  = 1'b1;
    dma_n = 1'b0;
    k = tick_cnt;
    wait_tick_cnt(k + 3000);
    n_vec++;
    if ({br_n, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL no_grant_req: br_n/busy=%b%b want 01", br_n, busy);
    end
    wait_tick_cnt(k + 6144);
    dma_n = 1'b1;
    wait_tick_cnt(k + 6145);
    n_vec++;
    if ({br_n, err, bank, busy} !== {2'b11, m_bank, 1'b0}) begin
      n_bad++;
      $display("FAIL no_grant_end: br/err/bank/busy=%b%b%b%b want 11%b0", br_n, err, bank, busy,
               m_bank);
    end
    n_vec++;
    if (wq.size() != 0) begin
      n_bad++;
      $display("FAIL no_grant_writes: got %0d want 0", wq.size());
    end
  endtask

  task automatic test_window_close();
    int g;
    start_grant($urandom_range(5, 1), g);
    wait_tick_cnt(g + 499);
    dma_n = 1'b1;
    wait_tick_cnt(g + 500);
    n_vec++;
    if ({br_n, src_rd_n, dst_wr_n, err, bank, busy} !== {4'b1111, m_bank, 1'b0}) begin
      n_bad++;
      $display("FAIL close_abort: br/rd/wr/err/bank/busy=%b%b%b%b%b%b want 1111%b0", br_n,
               src_rd_n, dst_wr_n, err, bank, busy, m_bank);
    end
    n_vec++;
    if (wq.size() != 499) begin
      n_bad++;
      $display("FAIL close_writes: got %0d want 499", wq.size());
    end
    check_words("close", 499, ~m_bank, g);
    bg_n = 1'b1;
    wait_tick_cnt(tick_cnt + 3);
    copy_window("recover", $urandom_range(6, 1));
  endtask

  task automatic test_grant_withdrawn();
    int g;
    start_grant($urandom_range(4, 1), g);
    wait_tick_cnt(g + 100);
    bg_n = 1'b1;
    wait_tick_cnt(g + 101);
    n_vec++;
    if ({br_n, src_rd_n, dst_wr_n, err, bank} !== {4'b1111, m_bank}) begin
      n_bad++;
      $display("FAIL withdraw_abort: br/rd/wr/err/bank=%b%b%b%b%b want 1111%b", br_n, src_rd_n,
               dst_wr_n, err, bank, m_bank);
    end
    n_vec++;
    if (wq.size() != 100) begin
      n_bad++;
      $display("FAIL withdraw_writes: got %0d want 100", wq.size());
    end
    check_words("withdraw", 100, ~m_bank, g);
    dma_n = 1'b1;
    wait_tick_cnt(tick_cnt + 3);
  endtask

  task automatic test_reset_mid_copy();
    int g;
    start_grant(2, g);
    wait_tick_cnt(g + 300);
    #2;
    rst_n = 1'b0;
    #1;
    m_bank = 1'b0;
    n_vec++;
    if ({br_n, src_rd_n, dst_wr_n, bank, busy, err, src_addr, dst_addr, dst_data} !== {3'b111,
        3'b000, 37'd0}) begin
      n_bad++;
      $display("FAIL async_reset: br/rd/wr/bank/busy/err=%b%b%b%b%b%b addr=%h/%h data=%h",
               br_n, src_rd_n, dst_wr_n, bank, busy, err, src_addr, dst_addr, dst_data);
    end
    step();
    step();
    rst_n = 1'b1;
    wq.delete();
    wait_tick_cnt(tick_cnt + 40);
    n_vec++;
    if ({br_n, busy} !== 2'b10 || wq.size() != 0) begin
      n_bad++;
      $display("FAIL no_restart: br_n/busy=%b%b writes=%0d want 10 and 0", br_n, busy,
               wq.size());
    end
    dma_n = 1'b1;
    bg_n  = 1'b1;
    wait_tick_cnt(tick_cnt + 2);
    copy_window("after_reset", 2);
  endtask

  task automatic test_entries4();
    int          k, g;
    logic [10:0] ea;
    en_mode = 1;
    gap_cnt = 0;
    fill_mem();
    wq4.delete();
    dma_n4 = 1'b0;
    k = tick_cnt;
    wait_tick_cnt(k + 1);
    n_vec++;
    if (br_n4 !== 1'b0) begin
      n_bad++;
      $display("FAIL e4_br_latency: br_n=%b want 0", br_n4);
    end
    wait_tick_cnt(k + 3);
    bg_n4 = 1'b0;
    g = tick_cnt + 1;
    wait_tick_cnt(g + E4);
    n_vec++;
    if ({br_n4, bank4} !== 2'b00) begin
      n_bad++;
      $display("FAIL e4_hold: br_n/bank=%b%b want 00", br_n4, bank4);
    end
    wait_tick_cnt(g + E4 + 1);
    n_vec++;
    if ({br_n4, dst_wr_n4, bank4, err4} !== 4'b1110) begin
      n_bad++;
      $display("FAIL e4_release: br/wr/bank/err=%b%b%b%b want 1110", br_n4, dst_wr_n4, bank4,
               err4);
    end
    n_vec++;
    if (wq4.size() != E4) begin
      n_bad++;
      $display("FAIL e4_write_count: got %0d want %0d", wq4.size(), E4);
    end
    for (int i = 0; i < int'(E4) && i < wq4.size(); i++) begin
      ea = {1'b1, 10'(i)};
      n_vec++;
      if ({wq4[i].addr, wq4[i].data} !== {ea, mem4[i]} || wq4[i].tick != g + 1 + i) begin
        n_bad++;
        $display("FAIL e4_word[%0d]: got %h/%h@%0d want %h/%h@%0d", i, wq4[i].addr,
                 wq4[i].data, wq4[i].tick, ea, mem4[i], g + 1 + i);
      end
    end
    bg_n4  = 1'b1;
    dma_n4 = 1'b1;
    wait_tick_cnt(tick_cnt + 4);
    n_vec++;
    if ({bank4, busy4, wq4.size() == E4} !== 3'b101) begin
      n_bad++;
      $display("FAIL e4_bank_once: bank/busy=%b%b writes=%0d want 10 and %0d", bank4, busy4,
               wq4.size(), E4);
    end
  endtask

  initial begin
    fill_mem();
    test_reset();
    test_normal_copy();
    test_no_grant();
    test_window_close();
    test_grant_withdrawn();
    test_reset_mid_copy();
    test_entries4();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
